// File: rtl/operand_regfile_if.sv
// Decoder/ALU-facing bundle of the operand stage: phase, read/write controls in,
// captured operands and flags out.
interface operand_regfile_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3,
    parameter int unsigned IW = 8
);
    logic [4:0]    phase;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          use_im;
    logic [IW-1:0] im;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          flag_we;
    logic          cf_in;
    logic          of_in;
    logic [DW-1:0] tr;
    logic [DW-1:0] sr;
    logic          cf;
    logic          of;
    logic          zf;
    logic          sf;

    modport master (
        output phase, ra, rb, use_im, im, we, wa, wd, flag_we, cf_in, of_in,
        input  tr, sr, cf, of, zf, sf
    );

    modport slave (
        input  phase, ra, rb, use_im, im, we, wa, wd, flag_we, cf_in, of_in,
        output tr, sr, cf, of, zf, sf
    );
endinterface

// File: rtl/operand_regfile.sv
// Operand stage: register file, tr/sr operand capture in phase r, result and
// flag commit plus retired-instruction count in phase w.
module operand_regfile #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3,
    parameter int unsigned IW = 8,
    parameter int unsigned CW = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    operand_regfile_if.slave    bus,
    input  logic [AW-1:0]       dbg_sel,
    output logic [DW-1:0]       dbg_data,
    output logic [CW-1:0]       icount
);
    localparam int unsigned NREG = 1 << AW;

    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];
    logic [DW-1:0] tr_q, tr_d;
    logic [DW-1:0] sr_q, sr_d;
    logic          cf_q, cf_d;
    logic          of_q, of_d;
    logic          zf_q, zf_d;
    logic          sf_q, sf_d;
    logic [CW-1:0] icount_q, icount_d;

    logic          ph_r;
    logic          ph_w;
    logic [DW-1:0] im_ext;

    assign ph_r   = bus.phase[1];
    assign ph_w   = bus.phase[4];
    assign im_ext = {{(DW-IW){bus.im[IW-1]}}, bus.im};

    // Operand reads always come from rf_q, so a combined r+w edge sees the
    // pre-write contents without any forwarding path.
    always_comb begin
        rf_d     = rf_q;
        tr_d     = tr_q;
        sr_d     = sr_q;
        cf_d     = cf_q;
        of_d     = of_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        icount_d = icount_q;

        if (ph_r) begin
            tr_d = rf_q[bus.ra];
            sr_d = bus.use_im ? im_ext : rf_q[bus.rb];
        end

        if (ph_w) begin
            if (bus.we) begin
                rf_d[bus.wa] = bus.wd;
            end
            if (bus.flag_we) begin
                cf_d = bus.cf_in;
                of_d = bus.of_in;
                zf_d = (bus.wd == '0);
                sf_d = bus.wd[DW-1];
            end
            icount_d = icount_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            tr_q     <= '0;
            sr_q     <= '0;
            cf_q     <= 1'b0;
            of_q     <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            icount_q <= '0;
        end else begin
            rf_q     <= rf_d;
            tr_q     <= tr_d;
            sr_q     <= sr_d;
            cf_q     <= cf_d;
            of_q     <= of_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            icount_q <= icount_d;
        end
    end

    assign bus.tr   = tr_q;
    assign bus.sr   = sr_q;
    assign bus.cf   = cf_q;
    assign bus.of   = of_q;
    assign bus.zf   = zf_q;
    assign bus.sf   = sf_q;
    assign dbg_data = rf_q[dbg_sel];
    assign icount   = icount_q;
endmodule

// File: tb/tb_operand_regfile.sv
// Bench for operand_regfile: table of instructions run through f/r/x/m/w with a
// tr/sr scoreboard, plus hand sequences for idle, wrap, r+w overlap and reset.
module tb_operand_regfile;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned IW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned NREG = 1 << AW;

    localparam logic [4:0] PH_F = 5'b00001;
    localparam logic [4:0] PH_R = 5'b00010;
    localparam logic [4:0] PH_W = 5'b10000;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic [AW-1:0] dbg_sel = '0;
    logic [DW-1:0] dbg_data;
    logic [CW-1:0] icount;

    operand_regfile_if #(.DW(DW), .AW(AW), .IW(IW)) bus ();

    operand_regfile #(.DW(DW), .AW(AW), .IW(IW), .CW(CW)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .bus      (bus),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .icount   (icount)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic          use_im;
        logic [IW-1:0] im;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          flag_we;
        logic          cf_in;
        logic          of_in;
        logic [DW-1:0] exp_tr;
        logic [DW-1:0] exp_sr;
        logic [3:0]    exp_flags;   // {cf, of, zf, sf}
        logic [CW-1:0] exp_icount;
    } vec_t;

    typedef struct {
        logic [DW-1:0] tr;
        logic [DW-1:0] sr;
    } opnd_t;

    vec_t          vecs[9];
    opnd_t         sb[$];
    logic [DW-1:0] model_rf[NREG];
    logic [DW-1:0] model_tr;
    logic [DW-1:0] model_sr;
    logic [3:0]    model_flags;
    logic [CW-1:0] model_icount;
    int            checks = 0;
    int            errors = 0;

    function automatic vec_t mk(
        input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic use_im,
        input logic [IW-1:0] im, input logic we, input logic [AW-1:0] wa,
        input logic [DW-1:0] wd, input logic flag_we, input logic cf_in,
        input logic of_in, input logic [DW-1:0] exp_tr, input logic [DW-1:0] exp_sr,
        input logic [3:0] exp_flags, input logic [CW-1:0] exp_icount);
        vec_t v;
        v.ra = ra; v.rb = rb; v.use_im = use_im; v.im = im;
        v.we = we; v.wa = wa; v.wd = wd;
        v.flag_we = flag_we; v.cf_in = cf_in; v.of_in = of_in;
        v.exp_tr = exp_tr; v.exp_sr = exp_sr;
        v.exp_flags = exp_flags; v.exp_icount = exp_icount;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dbg_all(input string tag);
        for (int i = 0; i < NREG; i++) begin
            dbg_sel = AW'(i);
            #1;
            chk($sformatf("%s dbg r%0d", tag, i), 32'(dbg_data), 32'(model_rf[i]));
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, " tr"}, 32'(bus.tr), 32'(model_tr));
        chk({tag, " sr"}, 32'(bus.sr), 32'(model_sr));
        chk({tag, " flags"}, 32'({bus.cf, bus.of, bus.zf, bus.sf}), 32'(model_flags));
        chk({tag, " icount"}, 32'(icount), 32'(model_icount));
    endtask

    task automatic pop_operands(input string tag);
        opnd_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s sb: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            model_tr = e.tr;
            model_sr = e.sr;
            chk({tag, " tr"}, 32'(bus.tr), 32'(e.tr));
            chk({tag, " sr"}, 32'(bus.sr), 32'(e.sr));
        end
    endtask

    // Run one instruction; read-side inputs are scrambled outside phase r,
    // write-side inputs are held through every phase.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        for (int p = 0; p < 5; p++) begin
            tag = $sformatf("v%0d p%0d", idx, p);
            bus.phase   = 5'(1 << p);
            bus.we      = v.we;
            bus.wa      = v.wa;
            bus.wd      = v.wd;
            bus.flag_we = v.flag_we;
            bus.cf_in   = v.cf_in;
            bus.of_in   = v.of_in;
            if (p == 1) begin
                bus.ra = v.ra; bus.rb = v.rb; bus.use_im = v.use_im; bus.im = v.im;
                sb.push_back('{tr: v.exp_tr, sr: v.exp_sr});
            end else begin
                bus.ra     = AW'($urandom_range(0, NREG - 1));
                bus.rb     = AW'($urandom_range(0, NREG - 1));
                bus.use_im = 1'($urandom_range(0, 1));
                bus.im     = IW'($urandom);
            end
            clk_edge();
            if (p == 1) begin
                pop_operands(tag);
            end
            if (p < 4) begin
                chk_state(tag);
                dbg_sel = v.wa;
                #1;
                chk({tag, " gate"}, 32'(dbg_data), 32'(model_rf[v.wa]));
            end else begin
                if (v.we) model_rf[v.wa] = v.wd;
                model_flags  = v.exp_flags;
                model_icount = v.exp_icount;
                chk_state(tag);
                chk_dbg_all(tag);
            end
        end
    endtask

    initial begin
        vecs[0] = mk(3'd0, 3'd0, 1'b0, 8'h00, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 4'd1);
        vecs[1] = mk(3'd3, 3'd3, 1'b0, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h1234, 4'b1010, 4'd2);
        vecs[2] = mk(3'd3, 3'd0, 1'b1, 8'hF0, 1'b1, 3'd2, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h1234, 16'hFFF0, 4'b1010, 4'd3);
        vecs[3] = mk(3'd2, 3'd0, 1'b1, 8'h7F, 1'b1, 3'd0, 16'h5A5A, 1'b1, 1'b0, 1'b1, 16'h8000, 16'h007F, 4'b0100, 4'd4);
        vecs[4] = mk(3'd0, 3'd2, 1'b0, 8'h00, 1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h5A5A, 16'h8000, 4'b1101, 4'd5);
        vecs[5] = mk(3'd7, 3'd3, 1'b0, 8'h00, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h1234, 4'b1101, 4'd6);
        vecs[6] = mk(3'd3, 3'd7, 1'b1, 8'h80, 1'b1, 3'd1, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h1234, 16'hFF80, 4'b0000, 4'd7);
        vecs[7] = mk(3'd1, 3'd6, 1'b0, 8'h00, 1'b0, 3'd4, 16'h8000, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 4'b0000, 4'd8);
        vecs[8] = mk(3'd5, 3'd5, 1'b0, 8'h00, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 4'd9);

        for (int i = 0; i < NREG; i++) model_rf[i] = '0;
        model_tr = '0; model_sr = '0; model_flags = '0; model_icount = '0;

        // Reset held across edges with a write pending: nothing may change.
        bus.phase = PH_W | PH_R; bus.ra = 3'd0; bus.rb = 3'd0; bus.use_im = 1'b1; bus.im = 8'hFF;
        bus.we = 1'b1; bus.wa = 3'd1; bus.wd = 16'hAAAA;
        bus.flag_we = 1'b1; bus.cf_in = 1'b1; bus.of_in = 1'b1;
        clk_edge();
        clk_edge();
        chk_state("reset");
        chk_dbg_all("reset");
        @(negedge clk);
        n_rst = 1'b0;
        bus.phase = '0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Idle phases with active write controls: no state change.
        bus.phase = 5'b00000; bus.we = 1'b1; bus.wa = 3'd4; bus.wd = 16'hDEAD;
        bus.flag_we = 1'b1; bus.cf_in = 1'b1; bus.of_in = 1'b1;
        bus.ra = 3'd7; bus.rb = 3'd7; bus.use_im = 1'b0;
        clk_edge();
        chk_state("idle0");
        bus.phase = 5'b01101;
        clk_edge();
        chk_state("idle_fxm");
        chk_dbg_all("idle_fxm");

        // w-only edges up to the top of the 4-bit counter.
        bus.we = 1'b0; bus.flag_we = 1'b0;
        for (int n = 0; n < 6; n++) begin
            bus.phase = PH_W;
            clk_edge();
            model_icount = model_icount + 1'b1;
            chk($sformatf("wcount %0d", n), 32'(icount), 32'(model_icount));
        end
        chk("icount top", 32'(icount), 32'd15);

        // Combined r+w on r2: operands see old 8000, r2 becomes 7777, counter wraps.
        bus.phase = PH_R | PH_W; bus.ra = 3'd2; bus.rb = 3'd2; bus.use_im = 1'b0;
        bus.we = 1'b1; bus.wa = 3'd2; bus.wd = 16'h7777; bus.flag_we = 1'b0;
        sb.push_back('{tr: 16'h8000, sr: 16'h8000});
        clk_edge();
        pop_operands("rw");
        chk("rw icount wrap", 32'(icount), 32'd0);
        model_rf[2] = 16'h7777;
        model_icount = '0;
        chk_dbg_all("rw");

        bus.phase = PH_R; bus.ra = 3'd2; bus.rb = 3'd5; bus.we = 1'b0;
        sb.push_back('{tr: 16'h7777, sr: 16'hBEEF});
        clk_edge();
        pop_operands("post_rw");
        chk_state("post_rw");

        // Asynchronous reset mid-cycle: outputs clear before the next edge.
        bus.phase = PH_F;
        @(negedge clk);
        #5;
        n_rst = 1'b1;
        #1;
        for (int i = 0; i < NREG; i++) model_rf[i] = '0;
        model_tr = '0; model_sr = '0; model_flags = '0; model_icount = '0;
        chk_state("async_rst");
        chk_dbg_all("async_rst");
        bus.phase = PH_W; bus.we = 1'b1; bus.wa = 3'd6; bus.wd = 16'h1111;
        clk_edge();
        chk_state("rst_hold");
        dbg_sel = 3'd6;
        #1;
        chk("rst_hold dbg r6", 32'(dbg_data), 32'd0);
        @(negedge clk);
        n_rst = 1'b0;
        bus.phase = '0;
        clk_edge();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
